proc_dispatch_port: RTL and testbench

//  Processor-side endpoint of the dispatcher start/spawn protocol; one instance per processor.

---
 rtl/proc_dispatch_port.sv | 107 ++++++++++
 tb/tb_proc_dispatch_port.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/proc_dispatch_port.sv
// rtl/proc_dispatch_port.sv - processor-side endpoint of the dispatcher start/spawn protocol
module proc_dispatch_port #(
  parameter int ADDR_W      = 8,
  parameter int SPAWN_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              disp_start,
  input  logic [ADDR_W-1:0] disp_start_addr,
  input  logic              disp_spawn_take,
  output logic              proc_running,
  output logic              proc_onspawn,
  output logic [ADDR_W-1:0] proc_spawn_addr,
  input  logic              core_spawn,
  input  logic [ADDR_W-1:0] core_spawn_addr,
  input  logic              core_halt,
  output logic              core_go,
  output logic [ADDR_W-1:0] core_pc,
  output logic              core_stall,
  output logic              err_overflow,
  output logic              err_start_busy
);

  localparam int PW = $clog2(SPAWN_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_t;
  state_t state;

  logic [ADDR_W-1:0] mem [SPAWN_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              push, pop, full, wr_en;

  assign full      = (count == CW'(SPAWN_DEPTH));
  assign push      = core_spawn && (state == RUN);
  assign pop       = disp_spawn_take && (count != '0);
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign wr_en     = push && (!full || pop);
  assign count_nxt = count + CW'(wr_en) - CW'(pop);

  assign proc_onspawn    = (count != '0);
  assign proc_spawn_addr = proc_onspawn ? mem[rd_ptr] : '0;
  assign core_stall      = full;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= core_spawn_addr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      if (push && full && !pop) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      proc_running   <= 1'b0;
      core_go        <= 1'b0;
      core_pc        <= '0;
      err_start_busy <= 1'b0;
    end else begin
      if (disp_start && state != IDLE) err_start_busy <= 1'b1;
      case (state)
        IDLE: begin
          if (disp_start) begin
            core_pc      <= disp_start_addr;
            core_go      <= 1'b1;
            proc_running <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          core_go <= 1'b0;
          state   <= RUN;
        end
        RUN: begin
          if (core_halt) begin
            if (count_nxt != '0) begin
              state <= DRAIN;
            end else begin
              state        <= IDLE;
              proc_running <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (count_nxt == '0) begin
            state        <= IDLE;
            proc_running <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_dispatch_port.sv
// tb/tb_proc_dispatch_port.sv - scoreboard bench for proc_dispatch_port
module tb_proc_dispatch_port;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       disp_start = 1'b0;
  logic [7:0] disp_start_addr = '0;
  logic       disp_spawn_take = 1'b0;
  logic       proc_running, proc_onspawn;
  logic [7:0] proc_spawn_addr;
  logic       core_spawn = 1'b0;
  logic [7:0] core_spawn_addr = '0;
  logic       core_halt = 1'b0;
  logic       core_go;
  logic [7:0] core_pc;
  logic       core_stall, err_overflow, err_start_busy;

  proc_dispatch_port #(.ADDR_W(8), .SPAWN_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .disp_start(disp_start), .disp_start_addr(disp_start_addr),
    .disp_spawn_take(disp_spawn_take),
    .proc_running(proc_running), .proc_onspawn(proc_onspawn),
    .proc_spawn_addr(proc_spawn_addr),
    .core_spawn(core_spawn), .core_spawn_addr(core_spawn_addr),
    .core_halt(core_halt), .core_go(core_go), .core_pc(core_pc),
    .core_stall(core_stall), .err_overflow(err_overflow),
    .err_start_busy(err_start_busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: 0 idle, 1 launch, 2 run, 3 drain
  logic [7:0] q[$];
  int         m_state = 0;
  logic [7:0] m_pc = '0;
  logic       m_ovf = 1'b0;
  logic       m_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("running", 32'(proc_running), 32'(m_state != 0));
    chk("go",      32'(core_go),      32'(m_state == 1));
    chk("pc",      32'(core_pc),      32'(m_pc));
    chk("onspawn", 32'(proc_onspawn), 32'(q.size() != 0));
    chk("stall",   32'(core_stall),   32'(q.size() == 4));
    chk("ovf",     32'(err_overflow), 32'(m_ovf));
    chk("busy",    32'(err_start_busy), 32'(m_busy));
    if (q.size() != 0) chk("head", 32'(proc_spawn_addr), 32'(q[0]));
  endtask

  // Called at a negedge: drive one cycle of stimulus, update model, check after the edge.
  task automatic step(input logic sp, input logic [7:0] sa, input logic tk,
                      input logic hl, input logic st, input logic [7:0] sta);
    logic popped;
    popped = 1'b0;
    core_spawn = sp; core_spawn_addr = sa; disp_spawn_take = tk;
    core_halt = hl; disp_start = st; disp_start_addr = sta;
    if (tk && q.size() != 0) begin
      chk("take_addr", 32'(proc_spawn_addr), 32'(q[0]));
      void'(q.pop_front());
      popped = 1'b1;
    end
    if (sp && m_state == 2) begin
      if (q.size() < 4) q.push_back(sa);
      else m_ovf = 1'b1;
    end
    if (st && m_state != 0) m_busy = 1'b1;
    case (m_state)
      0: if (st) begin m_state = 1; m_pc = sta; end
      1: m_state = 2;
      2: if (hl) m_state = (q.size() != 0) ? 3 : 0;
      3: if (q.size() == 0) m_state = 0;
      default: m_state = 0;
    endcase
    @(posedge clock);
    @(negedge clock);
    core_spawn = 1'b0; disp_spawn_take = 1'b0; core_halt = 1'b0; disp_start = 1'b0;
    check_outputs();
  endtask

  task automatic idle(); step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00); endtask
  task automatic push(input logic [7:0] a); step(1'b1, a, 1'b0, 1'b0, 1'b0, 8'h00); endtask
  task automatic take(); step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); endtask
  task automatic halt(); step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00); endtask
  task automatic start(input logic [7:0] a); step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a); endtask

  initial begin
    #12;
    check_outputs();
    chk("rst_addr", 32'(proc_spawn_addr), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: start and launch
    start(8'h3C);
    chk("t1_go", 32'(core_go), 32'h1);
    idle();
    chk("t1_go_low", 32'(core_go), 32'h0);

    // 2: in-order push/take
    push(8'h05); push(8'h06); push(8'h07);
    take(); take(); take();
    chk("t2_empty", 32'(proc_onspawn), 32'h0);

    // 3: full, overflow, push+take while full, empty+push+take
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    chk("t3_stall", 32'(core_stall), 32'h1);
    push(8'h14);
    chk("t3_ovf", 32'(err_overflow), 32'h1);
    chk("t3_head", 32'(proc_spawn_addr), 32'h10);
    step(1'b1, 8'h15, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("t3_full_keep", 32'(core_stall), 32'h1);
    take(); take(); take(); take();
    step(1'b1, 8'h16, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("t3_empty_push", 32'(proc_spawn_addr), 32'h16);
    take();

    // 4: spawn+halt together, drain two entries
    push(8'h20);
    step(1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("t4_drain", 32'(proc_running), 32'h1);
    push(8'h22);
    take();
    chk("t4_still", 32'(proc_running), 32'h1);
    take();
    chk("t4_free", 32'(proc_running), 32'h0);

    // 5: busy start, halt with empty FIFO
    start(8'h40); idle();
    start(8'h99);
    chk("t5_busy", 32'(err_start_busy), 32'h1);
    chk("t5_pc", 32'(core_pc), 32'h40);
    halt();
    chk("t5_idle", 32'(proc_running), 32'h0);

    // 6: async reset mid-drain with 3 entries
    start(8'h50); idle();
    push(8'h31); push(8'h32);
    step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_drain", 32'(proc_running), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    q.delete(); m_state = 0; m_pc = '0; m_ovf = 1'b0; m_busy = 1'b0;
    check_outputs();
    chk("t6_addr", 32'(proc_spawn_addr), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    chk("t6_onspawn", 32'(proc_onspawn), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
